// File: rtl/seq_det_pkg.sv
// -----------------------------------------------------------------------------
// seq_det_pkg
// Shared definitions for the parametrised serial pattern detector:
//   - detector FSM state encoding
//   - default values for pattern width, reset pattern and counter width
//   - legal pattern-width bounds plus a helper that checks them
// -----------------------------------------------------------------------------
package seq_det_pkg;

  // Detector state: FILL while history is too short to match, ARMED afterwards.
  typedef enum logic {
    ST_FILL  = 1'b0,
    ST_ARMED = 1'b1
  } state_e;

  localparam int unsigned      DEF_PAT_W   = 3;
  localparam logic [2:0]       DEF_PATTERN = 3'b101;
  localparam int unsigned      DEF_CNT_W   = 8;

  localparam int unsigned      PAT_W_MIN   = 2;
  localparam int unsigned      PAT_W_MAX   = 16;

  // True when a pattern width lies within the supported range.
  function automatic bit pat_w_legal(input int unsigned w);
    return (w >= PAT_W_MIN) && (w <= PAT_W_MAX);
  endfunction

endpackage : seq_det_pkg

// File: rtl/seq_detector_param_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with a synchronous clear. A clear in the same cycle
// as an increment leaves the counter at 1, so no event is lost.
// Ports:
//   clk   in   rising-edge clock
//   reset in   synchronous active-high reset (count -> 0)
//   clr   in   clear request
//   inc   in   increment request
//   cnt   out  registered count, sticks at all-ones
//   sat   out  registered flag, 1 while cnt is all-ones
// -----------------------------------------------------------------------------
module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         sat
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  logic [W-1:0] cnt_q, cnt_d;
  logic         sat_q, sat_d;

  // Next count: clear wins but still honours a simultaneous increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = inc ? W'(1) : W'(0);
    end else if (inc && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + W'(1);
    end else begin
      cnt_d = cnt_q;
    end
    // Flag is computed from the next value so it is registered alongside it.
    sat_d = (cnt_d == CNT_MAX);
  end

  // Counter and saturation flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= W'(0);
      sat_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sat_q <= sat_d;
    end
  end

  assign cnt = cnt_q;
  assign sat = sat_q;

endmodule : sat_counter

// File: rtl/seq_detector_param.sv
// -----------------------------------------------------------------------------
// seq_detector_param
// Serial bit-pattern detector with a run-time loadable pattern, overlapping
// or restarting match mode, input qualification and a saturating match count.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   din        in   serial data bit
//   in_valid   in   din is sampled only when 1
//   overlap    in   1: matches may share bits; 0: history restarts after a match
//   pat_load   in   load pat_in as the new pattern (discards din that cycle)
//   pat_in     in   new pattern, MSB is the first bit received
//   clear_cnt  in   clear the match counter
//   match      out  registered one-cycle pulse per detected pattern
//   match_cnt  out  registered saturating number of matches
//   cnt_sat    out  1 while match_cnt is all-ones
// -----------------------------------------------------------------------------
module seq_detector_param
  import seq_det_pkg::*;
#(
  parameter int unsigned       PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0]  PATTERN = PAT_W'(DEF_PATTERN),
  parameter int unsigned       CNT_W   = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             din,
  input  logic             in_valid,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             clear_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             cnt_sat
);

  // An unsupported width stops elaboration on a missing module.
  if (!pat_w_legal(PAT_W)) begin : g_bad_pat_w
    seq_detector_param_illegal_pat_w u_illegal_pat_w ();
  end

  localparam int unsigned          FILL_W   = $clog2(PAT_W);
  localparam logic [FILL_W-1:0]    FILL_MAX = FILL_W'(PAT_W - 1);

  // Only the newest PAT_W-1 bits are stored: the oldest bit of a PAT_W-wide
  // history would be shifted out before it could ever take part in a compare.
  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  state_e            state_q, state_d;
  logic [PAT_W-1:0]  pat_q, pat_d;
  logic              match_q, match_d;

  logic [PAT_W-1:0]  window_s;
  logic              hit_s;

  // Candidate window formed by the stored history plus the incoming bit.
  assign window_s = {hist_q, din};
  assign hit_s    = (state_q == ST_ARMED) && in_valid && !pat_load &&
                    (window_s == pat_q);

  // Next-state logic for history, fill level, FSM state and match pulse.
  always_comb begin
    hist_d  = hist_q;
    fill_d  = fill_q;
    state_d = state_q;
    pat_d   = pat_q;
    match_d = 1'b0;

    if (pat_load) begin
      // A new pattern invalidates everything collected so far.
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = FILL_W'(0);
      state_d = ST_FILL;
    end else if (in_valid) begin
      hist_d = window_s[PAT_W-2:0];
      if (hit_s) begin
        match_d = 1'b1;
        if (!overlap) begin
          // Bits consumed by this match may not seed the next one.
          hist_d  = '0;
          fill_d  = FILL_W'(0);
          state_d = ST_FILL;
        end else begin
          fill_d  = fill_q;
          state_d = state_q;
        end
      end else if (fill_q != FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
        if (fill_d == FILL_MAX) begin
          state_d = ST_ARMED;
        end else begin
          state_d = ST_FILL;
        end
      end else begin
        fill_d  = fill_q;
        state_d = state_q;
      end
    end else begin
      // Gap in the input stream: everything holds.
      hist_d  = hist_q;
      fill_d  = fill_q;
      state_d = state_q;
    end
  end

  // Detector registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= '0;
      fill_q  <= FILL_W'(0);
      state_q <= ST_FILL;
      pat_q   <= PATTERN;
      match_q <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      pat_q   <= pat_d;
      match_q <= match_d;
    end
  end

  // Counter steps on the same edge that raises the match pulse.
  sat_counter #(
    .W (CNT_W)
  ) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (clear_cnt),
    .inc   (match_d),
    .cnt   (match_cnt),
    .sat   (cnt_sat)
  );

  assign match = match_q;

endmodule : seq_detector_param

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;

  localparam int unsigned      PAT_W   = 3;
  localparam logic [PAT_W-1:0] PATTERN = 3'b101;
  localparam int unsigned      CNT_W   = 2;
  localparam int               CNT_MAX = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             din = 1'b0;
  logic             in_valid = 1'b0;
  logic             overlap = 1'b1;
  logic             pat_load = 1'b0;
  logic [PAT_W-1:0] pat_in = '0;
  logic             clear_cnt = 1'b0;
  logic             match;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  seq_detector_param #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .din       (din),
    .in_valid  (in_valid),
    .overlap   (overlap),
    .pat_load  (pat_load),
    .pat_in    (pat_in),
    .clear_cnt (clear_cnt),
    .match     (match),
    .match_cnt (match_cnt),
    .cnt_sat   (cnt_sat)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural reference ----------------
  // Keeps the accepted bits since the last restart as a list, and declares
  // a match when the most recent PAT_W of them spell the pattern.
  bit               bits_q[$];
  logic [PAT_W-1:0] m_pat = PATTERN;
  bit               exp_match = 1'b0;
  int               exp_cnt = 0;
  bit               exp_sat = 1'b0;

  always @(posedge clk) begin
    bit hit;
    hit = 1'b0;
    if (reset) begin
      bits_q.delete();
      m_pat   = PATTERN;
      exp_cnt = 0;
    end else begin
      if (pat_load) begin
        bits_q.delete();
        m_pat = pat_in;
      end else if (in_valid) begin
        bits_q.push_back(din);
        if (bits_q.size() > PAT_W) void'(bits_q.pop_front());
        if (bits_q.size() == PAT_W) begin
          hit = 1'b1;
          for (int i = 0; i < PAT_W; i++)
            if (bits_q[i] != m_pat[PAT_W-1-i]) hit = 1'b0;
        end
        if (hit && !overlap) bits_q.delete();
      end
      if (clear_cnt) exp_cnt = hit ? 1 : 0;
      else if (hit && exp_cnt < CNT_MAX) exp_cnt = exp_cnt + 1;
    end
    exp_match = hit;
    exp_sat   = (exp_cnt == CNT_MAX);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Every-cycle comparison against the reference, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("match", 32'(match), 32'(exp_match));
      check("match_cnt", 32'(match_cnt), 32'(exp_cnt));
      check("cnt_sat", 32'(cnt_sat), 32'(exp_sat));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic send(input bit d, input bit v);
    din = d;
    in_valid = v;
    step();
    in_valid = 1'b0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) step();
    reset = 1'b0;
  endtask

  initial begin
    // Reset state
    do_reset(2);
    chk_en = 1'b1;
    check("reset_match", 32'(match), 32'd0);
    check("reset_cnt", 32'(match_cnt), 32'd0);
    check("reset_sat", 32'(cnt_sat), 32'd0);

    // Overlapping detection: 1,0,1,0,1 -> two matches
    overlap = 1'b1;
    send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
    check("ovl_first_pulse", 32'(match), 32'd1);
    send(1'b0, 1'b1);
    check("ovl_pulse_one_cycle", 32'(match), 32'd0);
    send(1'b1, 1'b1);
    check("ovl_second_pulse", 32'(match), 32'd1);
    check("ovl_cnt", 32'(match_cnt), 32'd2);

    // Non-overlap mode: 1,0,1,0,1 -> one match, then 1,0,1 -> second
    do_reset(1);
    overlap = 1'b0;
    send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
    send(1'b0, 1'b1); send(1'b1, 1'b1);
    check("novl_cnt1", 32'(match_cnt), 32'd1);
    send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
    check("novl_cnt2", 32'(match_cnt), 32'd2);

    // Input gaps are transparent
    do_reset(1);
    overlap = 1'b1;
    send(1'b1, 1'b1);
    send(1'b0, 1'b0); send(1'b1, 1'b0); send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    send(1'b1, 1'b0);
    check("gap_no_early", 32'(match), 32'd0);
    send(1'b1, 1'b1);
    check("gap_pulse", 32'(match), 32'd1);
    check("gap_cnt", 32'(match_cnt), 32'd1);

    // Pattern reload: din in the load cycle is discarded
    do_reset(1);
    pat_load = 1'b1; pat_in = 3'b110;
    send(1'b1, 1'b1);
    pat_load = 1'b0;
    send(1'b1, 1'b1); send(1'b1, 1'b1);
    check("load_no_early", 32'(match), 32'd0);
    send(1'b0, 1'b1);
    check("load_pulse", 32'(match), 32'd1);
    send(1'b1, 1'b1); send(1'b0, 1'b1); send(1'b1, 1'b1);
    check("load_old_pat_dead", 32'(match_cnt), 32'd1);

    // Reset mid-stream
    do_reset(1);
    send(1'b1, 1'b1); send(1'b0, 1'b1);
    do_reset(1);
    send(1'b1, 1'b1);
    check("midrst_no_match", 32'(match), 32'd0);
    check("midrst_cnt", 32'(match_cnt), 32'd0);
    send(1'b0, 1'b1); send(1'b1, 1'b1);
    check("midrst_later_match", 32'(match_cnt), 32'd1);

    // Saturation and clear with simultaneous match
    do_reset(1);
    send(1'b1, 1'b1);
    repeat (5) begin
      send(1'b0, 1'b1); send(1'b1, 1'b1);
    end
    check("sat_cnt", 32'(match_cnt), 32'd3);
    check("sat_flag", 32'(cnt_sat), 32'd1);
    send(1'b0, 1'b1);
    clear_cnt = 1'b1;
    send(1'b1, 1'b1);
    clear_cnt = 1'b0;
    check("clr_match_cnt", 32'(match_cnt), 32'd1);
    check("clr_match_sat", 32'(cnt_sat), 32'd0);
    clear_cnt = 1'b1;
    send(1'b0, 1'b0);
    clear_cnt = 1'b0;
    check("clr_only_cnt", 32'(match_cnt), 32'd0);

    // Randomized traffic against the reference
    for (int i = 0; i < 4000; i++) begin
      reset     = ($urandom_range(0, 199) == 0);
      pat_load  = ($urandom_range(0, 59) == 0);
      pat_in    = PAT_W'($urandom);
      clear_cnt = ($urandom_range(0, 24) == 0);
      if ((i % 64) == 0) overlap = 1'($urandom);
      din       = 1'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      step();
    end
    reset = 1'b0; pat_load = 1'b0; clear_cnt = 1'b0; in_valid = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_seq_detector_param
